// File: rtl/fpro_uart_master_if.sv
// rtl/fpro_uart_master_if.sv - FPro MMIO bus bundle between the UART bus master and the MMIO controller
interface fpro_uart_master_if;
  logic        cs;
  logic        wr;
  logic        rd;
  logic [20:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, wr, rd, addr, wr_data, input rd_data);
  modport slave  (input cs, wr, rd, addr, wr_data, output rd_data);
endinterface

// File: rtl/fpro_uart_master.sv
// rtl/fpro_uart_master.sv - UART byte commands ('R'/'W' frames) to single FPro MMIO bus cycles
// Optional inter-byte abort timer enabled by defining FPRO_UART_MASTER_TIMEOUT_EN.
module fpro_uart_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_empty,
  input  logic [7:0]         i_rx_data,
  output logic               o_rx_rd,
  input  logic               i_tx_full,
  output logic               o_tx_wr,
  output logic [7:0]         o_tx_data,
  fpro_uart_master_if.master mmio,
  output logic               o_busy
);
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_is_wr;
  logic [1:0]  r_cnt;
  logic [20:0] r_addr_sh;
  logic [23:0] r_wdata_sh;
  logic [23:0] r_rdata_sh;
  logic [7:0]  r_tx_data;
  logic        r_cs;
  logic        r_wr;
  logic        r_rd;
  logic [20:0] r_mmio_addr;
  logic [31:0] r_mmio_wdata;
  logic        r_busy;
  logic        w_pop;
  logic        w_push;
  logic        w_timeout;
  logic        w_is_cmd;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  assign w_is_cmd = (i_rx_data == CMD_RD) || (i_rx_data == CMD_WR);

`ifdef FPRO_UART_MASTER_TIMEOUT_EN
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TIMER_W-1:0] r_timer;
  logic               w_waiting;

  // Counts consecutive starved cycles mid-frame; any pop or state change restarts it.
  assign w_waiting = ((r_state == S_ADDR) || (r_state == S_DATA)) && i_rx_empty;
  assign w_timeout = w_waiting && (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || !w_waiting || w_timeout) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_rx_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = w_is_cmd ? S_ADDR : S_RESP;
        end
      end
      S_ADDR: begin
        if (!i_rx_empty) begin
          w_pop = 1'b1;
          if (r_cnt == 2'd2) begin
            w_state_nxt = r_is_wr ? S_DATA : S_BUS;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_DATA: begin
        if (!i_rx_empty) begin
          w_pop = 1'b1;
          if (r_cnt == 2'd3) begin
            w_state_nxt = S_BUS;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_BUS: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (!i_tx_full) begin
          w_push = 1'b1;
          if (r_cnt == 2'd0) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // FIFO strobes are combinational, so keep them quiet while reset is held.
    if (i_reset) begin
      w_pop  = 1'b0;
      w_push = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_is_wr      <= 1'b0;
      r_cnt        <= 2'd0;
      r_addr_sh    <= '0;
      r_wdata_sh   <= '0;
      r_rdata_sh   <= '0;
      r_tx_data    <= '0;
      r_cs         <= 1'b0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_mmio_addr  <= '0;
      r_mmio_wdata <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_cs   <= (w_state_nxt == S_BUS);
      r_wr   <= (w_state_nxt == S_BUS) && r_is_wr;
      r_rd   <= (w_state_nxt == S_BUS) && !r_is_wr;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_is_wr <= (i_rx_data == CMD_WR);
            r_cnt   <= 2'd0;
            if (!w_is_cmd) begin
              r_tx_data <= RSP_ERR;
            end
          end
        end
        S_ADDR: begin
          if (w_pop) begin
            // Shifting through 21 bits drops A2[7:5] on its own.
            r_addr_sh <= {r_addr_sh[12:0], i_rx_data};
            r_cnt     <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 1'b1;
            if (w_state_nxt == S_BUS) begin
              r_mmio_addr <= {r_addr_sh[12:0], i_rx_data};
            end
          end else if (w_timeout) begin
            r_tx_data <= RSP_ERR;
            r_cnt     <= 2'd0;
          end
        end
        S_DATA: begin
          if (w_pop) begin
            r_wdata_sh <= {r_wdata_sh[15:0], i_rx_data};
            r_cnt      <= r_cnt + 1'b1;
            if (r_cnt == 2'd3) begin
              r_mmio_addr  <= r_addr_sh;
              r_mmio_wdata <= {r_wdata_sh, i_rx_data};
            end
          end else if (w_timeout) begin
            r_tx_data <= RSP_ERR;
            r_cnt     <= 2'd0;
          end
        end
        S_BUS: begin
          if (r_is_wr) begin
            r_tx_data <= RSP_OK;
            r_cnt     <= 2'd0;
          end else begin
            r_tx_data  <= mmio.rd_data[31:24];
            r_rdata_sh <= mmio.rd_data[23:0];
            r_cnt      <= 2'd3;
          end
        end
        S_RESP: begin
          // r_cnt holds bytes remaining after the one currently on o_tx_data.
          if (w_push) begin
            r_tx_data  <= r_rdata_sh[23:16];
            r_rdata_sh <= {r_rdata_sh[15:0], 8'h00};
            r_cnt      <= r_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_rx_rd      = w_pop;
  assign o_tx_wr      = w_push;
  assign o_tx_data    = r_tx_data;
  assign o_busy       = r_busy;
  assign mmio.cs      = r_cs;
  assign mmio.wr      = r_wr;
  assign mmio.rd      = r_rd;
  assign mmio.addr    = r_mmio_addr;
  assign mmio.wr_data = r_mmio_wdata;
endmodule

// File: doc/fpro_uart_master.md
# fpro_uart_master

Bus-initiator bridge that turns a byte-oriented command stream from the UART receive FIFO into single FPro MMIO bus transactions and returns results through the UART transmit FIFO. It drives the initiator side of the FPro bus (mmio_cs/wr/rd/addr/wr_data) into the MMIO controller, allowing a host PC to peek and poke any slot register without the processor. It sits beside the UART PHY, between its FIFOs and the MMIO controller.

## Interface
- TIMEOUT_CYCLES, 1_000_000, inter-byte idle limit in clk cycles; effective only with FPRO_UART_MASTER_TIMEOUT_EN
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_empty  in  1  UART rx FIFO empty
- rx_data  in  8  rx FIFO head byte (first-word-fall-through), valid when rx_empty=0
- rx_rd  out  1  pop rx FIFO; consumes rx_data this cycle
- tx_full  in  1  UART tx FIFO full
- tx_wr  out  1  push tx_data into tx FIFO
- tx_data  out  8  response byte
- mmio_cs  out  1  FPro bus chip select
- mmio_wr  out  1  FPro write strobe
- mmio_rd  out  1  FPro read strobe
- mmio_addr  out  21  FPro word address
- mmio_wr_data  out  32  FPro write data
- mmio_rd_data  in  32  FPro read data, valid in the cycle mmio_cs&mmio_rd=1
- busy  out  1  high whenever state != IDLE

## Operation
- Frame format (bytes, MSB first): read = 0x52 'R', A2, A1, A0; write = 0x57 'W', A2, A1, A0, D3, D2, D1, D0.
- Address = {A2,A1,A0}[20:0]; A2[7:5] ignored.
- States: IDLE, ADDR, DATA, BUS, RESP.
- IDLE: pop one byte when rx_empty=0. 'R'/'W' -> latch op, clear byte counter, go ADDR. Any other byte -> queue error response 0x3F '?', go RESP.
- ADDR: pop 3 bytes, shifting into addr register. After 3rd: W -> DATA, R -> BUS.
- DATA: pop 4 bytes into wr_data register. After 4th -> BUS.
- BUS: exactly one cycle; mmio_cs=1 with mmio_wr=1 (W) or mmio_rd=1 (R); mmio_addr/mmio_wr_data from registers. R: capture mmio_rd_data at end of this cycle. -> RESP.
- RESP: W -> send 0x4B 'K' (1 byte). R -> send D3,D2,D1,D0 of captured word (4 bytes). Error -> send 0x3F. tx_wr=1 only when tx_full=0; after last byte -> IDLE.
- rx_rd asserted only in IDLE/ADDR/DATA with rx_empty=0; never in BUS/RESP (bytes arriving meanwhile stay in FIFO).
- mmio_cs/wr/rd are 0 in every state except BUS; mmio_addr/mmio_wr_data hold last values otherwise.

## Timing
- Reset: state IDLE; rx_rd, tx_wr, mmio_cs, mmio_wr, mmio_rd, busy = 0; tx_data, mmio_addr, mmio_wr_data = 0; counters cleared.
- rx_rd, tx_wr combinational from state and FIFO flags; all other outputs registered.
- Best case with FIFOs never empty/full: read frame = 4 pop cycles + 1 BUS + 4 RESP = 9 cycles; write frame = 8 + 1 + 1 = 10 cycles.
- tx_full held high stalls RESP indefinitely with no byte lost or duplicated; transmission resumes the cycle tx_full falls.
- reset asserted mid-frame or mid-RESP: next cycle IDLE, partial frame discarded, no bus cycle, no further tx bytes.
- Exactly one bus transaction per valid frame; never back-to-back BUS cycles.

## Configuration
- FPRO_UART_MASTER_TIMEOUT_EN defined: counter clears on every pop; in ADDR or DATA, if rx_empty stays 1 for TIMEOUT_CYCLES consecutive cycles, frame aborted -> RESP sending 0x3F, no bus cycle. Timer inactive in IDLE, BUS, RESP.
- Undefined: no counter logic; ADDR/DATA wait indefinitely for bytes.

## Test plan
- Write: push 57 00 00 21 DE AD BE EF -> one cycle mmio_cs=1, mmio_wr=1, mmio_addr=0x000021, mmio_wr_data=0xDEADBEEF; tx stream 4B.
- Read: push 52 1F FF 40 with mmio_rd_data=0x12345678 during BUS -> mmio_addr=0x1FFF40 (A2[7:5] dropped), mmio_rd=1 one cycle; tx stream 12 34 56 78.
- Bad command: push 41 -> no bus activity, tx 3F, back to IDLE; following 52 00 00 00 completes normally.
- Backpressure: read with tx_full high 20 cycles during RESP -> exactly 4 bytes, correct order, no duplicates.
- Reset after 57 00 00 -> busy=0 next cycle; then 52 00 00 02 executes a single read at 0x000002.
- With FPRO_UART_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16: push 52 00 then starve 16 cycles -> tx 3F, no mmio_cs pulse; without the macro, the same stimulus leaves busy=1 and emits nothing.
